// File: rtl/ila_capture_controller_pkg.sv
// Shared definitions for the logic-analyzer capture controller: FSM state
// encodings and default widths.
package ila_pkg;

  localparam int ILA_ADDR_WIDTH = 8;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/ila_capture_controller_if.sv
// Control/status bundle between the capture controller, its trigger stage,
// the sample buffer and the readout logic.
interface ila_capture_controller_if
  import ila_pkg::*;
#(
  parameter int ADDR_WIDTH = ILA_ADDR_WIDTH
);

  logic                  arm;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] pre_count;
  logic [ADDR_WIDTH-1:0] post_count;
  logic                  trigger;
  logic                  primed;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  wrapped;
  logic                  busy;
  logic                  done;
  logic [STATE_W-1:0]    state;

  modport master (
    output arm, abort, pre_count, post_count, trigger,
    input  primed, wr_en, wr_addr, trig_addr, wrapped, busy, done, state
  );

  modport slave (
    input  arm, abort, pre_count, post_count, trigger,
    output primed, wr_en, wr_addr, trig_addr, wrapped, busy, done, state
  );

endinterface

// File: rtl/ila_sample_counter.sv
// Loadable down-counter that saturates at zero; flags the last counted cycle
// and the empty (zero) condition.
module ila_sample_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_last = (r_count == WIDTH'(1));

endmodule

// File: rtl/ila_capture_controller.sv
// Capture sequencer: arm -> pre-trigger fill -> armed wait -> post-trigger
// fill -> done, driving the circular sample buffer write port.
module ila_capture_controller
  import ila_pkg::*;
#(
  parameter int ADDR_WIDTH = ILA_ADDR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  ila_capture_controller_if.slave  bus
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic                  r_wrapped;
  logic                  w_accept_arm;
  logic                  w_write;
  logic                  w_pre_zero;
  logic                  w_pre_last;
  logic                  w_post_zero;
  logic                  w_post_last;

  assign w_accept_arm = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.arm && !bus.abort;
  assign w_write      = (r_state == ST_PREFILL) || (r_state == ST_ARMED) || (r_state == ST_POST);

  ila_sample_counter #(.WIDTH(ADDR_WIDTH)) u_pre_counter (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_accept_arm),
    .i_load_value (bus.pre_count),
    .i_dec        (r_state == ST_PREFILL),
    .o_zero       (w_pre_zero),
    .o_last       (w_pre_last)
  );

  ila_sample_counter #(.WIDTH(ADDR_WIDTH)) u_post_counter (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_accept_arm),
    .i_load_value (bus.post_count),
    .i_dec        (r_state == ST_POST),
    .o_zero       (w_post_zero),
    .o_last       (w_post_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            w_next_state = (bus.pre_count == '0) ? ST_ARMED : ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (w_pre_last || w_pre_zero) begin
            w_next_state = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (bus.trigger) begin
            w_next_state = w_post_zero ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (w_post_last || w_post_zero) begin
            w_next_state = ST_DONE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // The sample written in the trigger cycle sits at the current address,
  // so trig_addr captures wr_addr before it advances.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_addr   <= '0;
      r_wrapped   <= 1'b0;
      r_trig_addr <= '0;
    end else begin
      if (w_accept_arm) begin
        r_wr_addr <= '0;
        r_wrapped <= 1'b0;
      end else if (w_write) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        if (r_wr_addr == '1) begin
          r_wrapped <= 1'b1;
        end
      end
      if ((r_state == ST_ARMED) && bus.trigger && !bus.abort) begin
        r_trig_addr <= r_wr_addr;
      end
    end
  end

  assign bus.wr_en     = w_write;
  assign bus.busy      = w_write;
  assign bus.primed    = (r_state == ST_ARMED);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.wr_addr   = r_wr_addr;
  assign bus.trig_addr = r_trig_addr;
  assign bus.wrapped   = r_wrapped;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_ila_capture_controller.sv
// Drives identical capture sequences into an 8-bit and a 4-bit address
// controller and compares every cycle against a capture-arithmetic model.
module tb_ila_capture_controller;

  logic       clock;
  logic       reset;
  logic       arm;
  logic       abort;
  logic       trigger;
  logic [7:0] pre;
  logic [7:0] post;

  int vectors;
  int miscompares;
  int expTrig [2];

  ila_capture_controller_if #(.ADDR_WIDTH(8)) bus8 ();
  ila_capture_controller_if #(.ADDR_WIDTH(4)) bus4 ();

  assign bus8.arm        = arm;
  assign bus8.abort      = abort;
  assign bus8.trigger    = trigger;
  assign bus8.pre_count  = pre;
  assign bus8.post_count = post;
  assign bus4.arm        = arm;
  assign bus4.abort      = abort;
  assign bus4.trigger    = trigger;
  assign bus4.pre_count  = pre[3:0];
  assign bus4.post_count = post[3:0];

  ila_capture_controller #(.ADDR_WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  ila_capture_controller #(.ADDR_WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [23:0] obs8;
  logic [23:0] obs4;
  assign obs8 = {bus8.trig_addr, bus8.wrapped, bus8.state, bus8.busy, bus8.done,
                 bus8.primed, bus8.wr_en, bus8.wr_addr};
  assign obs4 = {4'b0, bus4.trig_addr, bus4.wrapped, bus4.state, bus4.busy, bus4.done,
                 bus4.primed, bus4.wr_en, 4'b0, bus4.wr_addr};

  function automatic logic [23:0] obs_of(input int d);
    return (d == 0) ? obs8 : obs4;
  endfunction

  // Expected observation from capture state number, samples written so far
  // and the trigger address; depth is the buffer size of the DUT in question.
  function automatic logic [23:0] exp_vec(input int st, input int writes, input int depth, input int trig);
    logic [7:0] a;
    logic [7:0] t;
    logic       bz;
    a  = 8'(writes % depth);
    t  = 8'(trig);
    bz = (st >= 1) && (st <= 3);
    return {t, (writes >= depth), 3'(st), bz, (st == 4), (st == 2), bz, a};
  endfunction

  task automatic test_reset();
    logic [23:0] e;
    reset = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0; pre = '0; post = '0;
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs_of(d) !== 24'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold dut%0d: got %h expected %h", d, obs_of(d), 24'h0);
      end
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = exp_vec(0, 0, (d == 0) ? 256 : 16, 0);
      vectors++;
      if (obs_of(d) !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_release dut%0d: got %h expected %h", d, obs_of(d), e);
      end
    end
    expTrig[0] = 0;
    expTrig[1] = 0;
  endtask

  // One full capture; with noise set, stray triggers outside ARMED and stray
  // arms during POST are injected and must have no effect.
  task automatic run_capture(input string name, input int pre_n, input int post_n,
                             input int wait_n, input bit noise);
    int total, trigC, st, writes, depth, trig;
    logic [23:0] e, o;
    total = pre_n + wait_n + 1 + post_n;
    trigC = pre_n + wait_n + 1;
    pre = 8'(pre_n); post = 8'(post_n);
    arm = 1'b1; abort = 1'b0; trigger = 1'b0;
    @(posedge clock);
    #1;
    arm = 1'b0;
    for (int c = 1; c <= total + 3; c++) begin
      writes = (c - 1 < total) ? c - 1 : total;
      st = (c <= pre_n) ? 1 : (c <= trigC) ? 2 : (c <= total) ? 3 : 4;
      for (int d = 0; d < 2; d++) begin
        depth = (d == 0) ? 256 : 16;
        trig  = (c > trigC) ? (trigC - 1) % depth : expTrig[d];
        e = exp_vec(st, writes, depth, trig);
        o = obs_of(d);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, c, o, e);
        end
      end
      trigger = (c == trigC) || (noise && (st != 2) && ($urandom_range(0, 2) == 0));
      arm     = noise && (st == 3) && ($urandom_range(0, 1) == 1);
      @(posedge clock);
      #1;
    end
    trigger = 1'b0; arm = 1'b0;
    expTrig[0] = (trigC - 1) % 256;
    expTrig[1] = (trigC - 1) % 16;
  endtask

  task automatic test_abort();
    int abortC, depth;
    logic [23:0] e;
    abortC = 2 + int'($urandom_range(0, 4)) + 1;
    pre = 8'd2; post = 8'd3;
    arm = 1'b1; abort = 1'b0; trigger = 1'b0;
    @(posedge clock);
    #1;
    arm = 1'b0;
    for (int c = 1; c < abortC; c++) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1; trigger = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0; trigger = 1'b0;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? 256 : 16;
      e = exp_vec(0, abortC, depth, expTrig[d]);
      vectors++;
      if (obs_of(d) !== e) begin
        miscompares++;
        $display("[TB] FAIL abort_with_trigger dut%0d: got %h expected %h", d, obs_of(d), e);
      end
    end
    arm = 1'b1; abort = 1'b1;
    @(posedge clock);
    #1;
    arm = 1'b0; abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? 256 : 16;
      e = exp_vec(0, abortC, depth, expTrig[d]);
      vectors++;
      if (obs_of(d) !== e) begin
        miscompares++;
        $display("[TB] FAIL abort_beats_arm dut%0d: got %h expected %h", d, obs_of(d), e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    pre = 8'd1; post = 8'd5;
    arm = 1'b1; abort = 1'b0; trigger = 1'b0;
    @(posedge clock);
    #1;
    arm = 1'b0;
    @(posedge clock);
    #1;
    trigger = 1'b1;
    @(posedge clock);
    #1;
    trigger = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs_of(d) !== 24'h0) begin
        miscompares++;
        $display("[TB] FAIL async_reset dut%0d: got %h expected %h", d, obs_of(d), 24'h0);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = exp_vec(0, 0, (d == 0) ? 256 : 16, 0);
      vectors++;
      if (obs_of(d) !== e) begin
        miscompares++;
        $display("[TB] FAIL async_reset_release dut%0d: got %h expected %h", d, obs_of(d), e);
      end
    end
    expTrig[0] = 0;
    expTrig[1] = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    run_capture("baseline", 4, 3, 2, 1'b0);
    run_capture("wrap", 2, 2, 20, 1'b0);
    run_capture("zero_counts", 0, 0, 0, 1'b0);
    run_capture("ignored_events", 3, 4, 5, 1'b1);
    test_abort();
    run_capture("rearm_after_abort", 0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_capture("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 30)), 1'b1);
    end
    run_capture("wrap8", 15, 15, 240, 1'b0);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ila_capture_controller.md
Name: ila_capture_controller

Overview:
- Sequences one logic-analyzer capture: arm, pre-trigger fill, armed wait, post-trigger fill, done.
- Drives the `primed` input of the trigger-generation stage and consumes its single-cycle `trigger` pulse.
- Produces write enable and address for the circular sample buffer, plus the trigger address and wrap status so readout logic can locate the oldest sample and the trigger sample.

Parameters:
ADDR_WIDTH, 8, sample-buffer address width; DEPTH = 2**ADDR_WIDTH.

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
arm  in  1  start-capture pulse; honoured only in IDLE or DONE
abort  in  1  cancel capture; honoured in any state
pre_count  in  ADDR_WIDTH  minimum pre-trigger samples; latched on accepted arm
post_count  in  ADDR_WIDTH  samples written after the trigger sample; latched on accepted arm
trigger  in  1  single-cycle pulse from the trigger stage
primed  out  1  high only in ARMED
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_WIDTH  buffer write address, valid when wr_en=1
trig_addr  out  ADDR_WIDTH  address holding the trigger sample
wrapped  out  1  address counter wrapped during this capture
busy  out  1  state is PREFILL, ARMED or POST
done  out  1  capture complete; level, held until next arm or abort
state  out  3  debug copy of FSM state

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; latched counts cleared.
- Outputs are Moore outputs registered from the state and counters.
  - wr_en = 1 exactly in PREFILL, ARMED and POST.
  - primed = 1 exactly in ARMED.
- States (encodings): IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.
- IDLE/DONE, arm=1 and abort=0:
  - Latch pre_count and post_count.
  - Next cycle: wr_addr=0, wrapped=0, done=0.
  - Next state is PREFILL, or ARMED if pre_count=0.
- PREFILL:
  - Lasts exactly pre_count cycles, one write per cycle.
  - ARMED follows the write of the pre_count-th sample.
  - trigger is ignored in PREFILL.
- ARMED:
  - Writes every cycle; waits indefinitely.
  - On trigger=1: trig_addr <= current wr_addr, because the sample written this cycle is the trigger sample.
  - Next state is POST, or DONE if post_count=0.
  - primed drops the cycle after the trigger.
- POST: lasts exactly post_count cycles, one write per cycle, then DONE.
- DONE: wr_en=0, primed=0, done=1, busy=0; trig_addr, wr_addr and wrapped hold.
- wr_addr:
  - Increments by 1 after every write; wraps modulo DEPTH (DEPTH-1 -> 0).
  - On a write to DEPTH-1, wrapped sets and stays set until the next accepted arm.
  - Readout: oldest sample = wr_addr if wrapped=1, else 0.
- If pre_count+post_count+1 > DEPTH, later samples overwrite the oldest ones (normal circular behaviour; no clamping).
- trigger outside ARMED is ignored; no pending trigger is stored.
- arm while busy is ignored.
- abort=1 in any state: next state IDLE; wr_en, primed, done and busy go 0. abort beats arm and trigger in the same cycle.
- Reset asserted mid-capture returns to IDLE immediately (async); the buffer contents are don't-care.

Decomposition:
- Package ila_pkg holds:
  - the state enum/encodings (3-bit);
  - the ILA_ADDR_WIDTH default;
  - the state-width constant.
- One natural sub-module: ila_sample_counter.
  - Loadable down-counter with terminal-count flag.
  - Instantiated twice, for the pre and post counts.
- The address counter and FSM stay in the top module.

Test Plan:
- Baseline:
  - Stimulus: ADDR_WIDTH=8, pre=4, post=3, arm at cycle 0, trigger at cycle 7.
  - Response: writes at addrs 0-3 (cycles 1-4, PREFILL), addrs 4-6 (ARMED, primed=1), trig_addr=6, addrs 7-9 (POST); done=1 at cycle 11; 10 writes total; wrapped=0.
- Wrap:
  - Stimulus: ADDR_WIDTH=4, pre=2, post=2, trigger after 20 ARMED cycles.
  - Response: wr_addr 15->0 wrap, wrapped=1, trig_addr=(2+20)%16=6 after 20 ARMED writes; final wr_addr=9.
- Zero counts:
  - Stimulus: pre=0, post=0, arm, trigger on the first ARMED cycle.
  - Response: exactly one write at addr 0, trig_addr=0, done the next cycle.
- Ignored events:
  - Stimulus: trigger during PREFILL and in DONE; arm during POST.
  - Response: no state change, no trig_addr update, write count unchanged.
- Abort:
  - Stimulus: abort together with trigger in ARMED.
  - Response: IDLE next cycle, trig_addr unchanged, done=0; a re-arm restarts at wr_addr=0.
- Async reset:
  - Stimulus: reset=0 mid-POST, between clock edges.
  - Response: all outputs 0 without waiting for a clock edge; after release, state=IDLE.
